mealy_scan_controller: RTL and testbench
========================================

// Module: mealy_scan_controller
// PURPOSE
//  Sequences a parallel word through a 2-output Mealy pattern detector, one bit per clock, LSB first.
//  Counts hits per detector output and reports results via a start/busy/done handshake.
//  Sits between a register-mapped host and the serial detector core. It owns the detector's
//  input stream and its history clear.
// PARAMETERS
//  WIDTH  10                   bits per scanned word (>=4)
//  CW     $clog2(WIDTH+1)      hit-counter width; counters cannot overflow
// PORTS
//  clock     in   1      single system clock, rising edge
//  reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      request scan of data; sampled only in IDLE
//  data      in   WIDTH  word to scan; captured on the accepting edge
//  hold      in   1      stall: while high in SCAN, no bit is consumed
//  busy      out  1      high in SCAN and DONE
//  done      out  1      one-cycle pulse; results valid from this cycle on
//  hit_a     out  1      per-cycle strobe, pattern A on the current bit
//  hit_b     out  1      per-cycle strobe, pattern B on the current bit
//  cnt_a     out  CW     number of pattern-A hits in the last/current scan
//  cnt_b     out  CW     number of pattern-B hits in the last/current scan
// BEHAVIOUR
//  - Reset values: all outputs 0, state IDLE, shift register 0, detector history 000.
//  - Detector: history h[2:0], h[0] = previous bit. Current bit is i.
//    - hit_a = i & ~h[1] & ~h[2]  (pattern 00x1, oldest first)
//    - hit_b = i & h[0] & h[2]    (pattern 1x11)
//    - History shifts in i on each consumed bit.
//  - IDLE: start=1 at an edge -> capture data, clear history, cnt_a/cnt_b, bit index=0 -> SCAN.
//  - SCAN, hold=0: present data[idx] to the detector.
//    - Combinational hits for bit idx drive hit_a/hit_b this cycle.
//    - Counters add the hits at the edge; history shifts; idx++.
//    - After idx=WIDTH-1 is consumed -> DONE.
//  - SCAN, hold=1: hit_a=hit_b=0; idx, history and counters frozen.
//  - DONE: done=1 for exactly one cycle -> IDLE. Hits are 0 in DONE and IDLE.
//  - Latency, hold never asserted:
//    - start accepted at edge E0.
//    - bits consumed at edges E1..EWIDTH.
//    - done high in the cycle after EWIDTH, i.e. WIDTH+1 cycles after E0.
//  - start while busy: ignored; no queuing.
//  - start and done in the same cycle: ignored, because the state is not IDLE.
//  - cnt_a/cnt_b hold their final values in IDLE until the next accepted start.
//  - Reset mid-scan: immediate return to IDLE, counts 0, no done pulse.
//  - Arithmetic: counters increment by 1 per hit, unsigned CW bits; max value WIDTH, no wrap.
// CONFIGURATION
//  - MEALY_SCAN_HIT_MAP_EN defined:
//    - adds outputs map_a, map_b [WIDTH-1:0]; bit k = 1 iff hit_a/hit_b fired on bit k.
//    - both maps clear on accepted start, update with the counters, and hold in IDLE.
//    - reset value 0.
//  - Not defined: ports and map registers absent; all other behaviour identical.
// STRUCTURE
//  - Package mealy_scan_pkg:
//    - state enum {S_IDLE, S_SCAN, S_DONE}
//    - HIST_W=3
//    - localparam masks/values for patterns A and B
//  - Sub-module mealy_pattern_core:
//    - 3-bit history; clear and advance inputs; combinational hit_a/hit_b.
//    - Instantiated once. The controller holds the FSM, shift register, index and counters.
// TESTING
//  1. data=10'b1001100111, hold=0:
//     - hit_a on bits 0,1,6
//     - cnt_a=3, cnt_b=0
//     - done exactly 11 cycles after the start edge
//  2. data=10'b0000001101:
//     - hit_a on bit 0, hit_b on bit 3
//     - cnt_a=1, cnt_b=1
//  3. Case 2 with hold=1 for 3 cycles after bit 1:
//     - same counts
//     - done delayed by exactly 3 cycles
//     - no hit strobes while hold=1
//  4. start pulsed again during SCAN and in the DONE cycle:
//     - ignored; one done only
//     - a start in the following IDLE cycle begins a new scan with counts cleared
//  5. reset asserted mid-scan (after 4 bits) asynchronously:
//     - busy, done and counts go 0 at once
//     - the next scan of case 1 gives cnt_a=3
//  6. MEALY_SCAN_HIT_MAP_EN: case 1 -> map_a=10'b0001000011, map_b=0.

Source files
------------

// File: rtl/mealy_scan_pkg.sv
// Shared types and pattern constants for the Mealy scan controller and its detector core.
package mealy_scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int unsigned HIST_W = 3;

   // History is {oldest, middle, previous}; a pattern matches when the masked history equals its value.
   localparam logic [HIST_W-1:0] PAT_A_MASK = 3'b110;
   localparam logic [HIST_W-1:0] PAT_A_VAL  = 3'b000;
   localparam logic [HIST_W-1:0] PAT_B_MASK = 3'b101;
   localparam logic [HIST_W-1:0] PAT_B_VAL  = 3'b101;

   function automatic logic pattern_hit(input logic bit_in, input logic [HIST_W-1:0] hist,
                                        input logic [HIST_W-1:0] mask, input logic [HIST_W-1:0] val);
      return bit_in & ((hist & mask) == val);
   endfunction

endpackage

// File: rtl/mealy_scan_controller_if.sv
// Host-side handshake and result bus of the scan controller.
// Map outputs exist only when MEALY_SCAN_HIT_MAP_EN is defined.
interface mealy_scan_controller_if #(
   parameter int unsigned WIDTH = 10
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic             start;
   logic [WIDTH-1:0] data;
   logic             hold;
   logic             busy;
   logic             done;
   logic             hit_a;
   logic             hit_b;
   logic [CW-1:0]    cnt_a;
   logic [CW-1:0]    cnt_b;
`ifdef MEALY_SCAN_HIT_MAP_EN
   logic [WIDTH-1:0] map_a;
   logic [WIDTH-1:0] map_b;
`endif

   modport master (
      output start, data, hold,
      input  busy, done, hit_a, hit_b, cnt_a, cnt_b
`ifdef MEALY_SCAN_HIT_MAP_EN
      , input map_a, map_b
`endif
   );

   modport slave (
      input  start, data, hold,
      output busy, done, hit_a, hit_b, cnt_a, cnt_b
`ifdef MEALY_SCAN_HIT_MAP_EN
      , output map_a, map_b
`endif
   );

endinterface

// File: rtl/mealy_pattern_core.sv
// Serial two-output Mealy detector: 3-bit history, clear/advance control, combinational hits.
module mealy_pattern_core
   import mealy_scan_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic advance,
   input  logic bit_in,
   output logic hit_a,
   output logic hit_b
);

   logic [HIST_W-1:0] hist;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hist <= '0;
      end else if (clear) begin
         hist <= '0;
      end else if (advance) begin
         hist <= {hist[HIST_W-2:0], bit_in};
      end
   end

   // Hits only mean something on a consumed bit, so they are gated by advance.
   assign hit_a = advance & pattern_hit(bit_in, hist, PAT_A_MASK, PAT_A_VAL);
   assign hit_b = advance & pattern_hit(bit_in, hist, PAT_B_MASK, PAT_B_VAL);

endmodule

// File: rtl/mealy_scan_controller.sv
// Scans a captured word LSB first through mealy_pattern_core and counts hits per pattern.
// Optional per-bit hit maps are built when MEALY_SCAN_HIT_MAP_EN is defined.
module mealy_scan_controller
   import mealy_scan_pkg::*;
#(
   parameter int unsigned WIDTH = 10
) (
   input logic                   clock,
   input logic                   reset,
   mealy_scan_controller_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [IW-1:0]    idx;
   logic             accept;
   logic             advance;
   logic             hit_a;
   logic             hit_b;

   assign accept  = (state == S_IDLE) & bus.start;
   assign advance = (state == S_SCAN) & ~bus.hold;

   mealy_pattern_core u_core (
      .clock   (clock),
      .reset   (reset),
      .clear   (accept),
      .advance (advance),
      .bit_in  (shreg[0]),
      .hit_a   (hit_a),
      .hit_b   (hit_b)
   );

   assign bus.hit_a = hit_a;
   assign bus.hit_b = hit_b;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         shreg     <= '0;
         idx       <= '0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.cnt_a <= '0;
         bus.cnt_b <= '0;
`ifdef MEALY_SCAN_HIT_MAP_EN
         bus.map_a <= '0;
         bus.map_b <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  shreg     <= bus.data;
                  idx       <= '0;
                  bus.cnt_a <= '0;
                  bus.cnt_b <= '0;
`ifdef MEALY_SCAN_HIT_MAP_EN
                  bus.map_a <= '0;
                  bus.map_b <= '0;
`endif
                  bus.busy  <= 1'b1;
                  state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (advance) begin
                  // Shift right so the next bit is always at shreg[0].
                  shreg     <= {1'b0, shreg[WIDTH-1:1]};
                  bus.cnt_a <= bus.cnt_a + CW'(hit_a);
                  bus.cnt_b <= bus.cnt_b + CW'(hit_b);
`ifdef MEALY_SCAN_HIT_MAP_EN
                  bus.map_a[idx] <= hit_a;
                  bus.map_b[idx] <= hit_b;
`endif
                  idx <= idx + IW'(1);
                  if (idx == IW'(WIDTH - 1)) begin
                     bus.done <= 1'b1;
                     state    <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mealy_scan_controller.sv
// Directed self-checking bench for mealy_scan_controller (WIDTH=10).
module tb_mealy_scan_controller;

   localparam int unsigned WIDTH = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   mealy_scan_controller_if #(.WIDTH(WIDTH)) bus ();

   mealy_scan_controller #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Cycle 1 is the cycle right after the accepting edge; done is expected in cycle WIDTH+1+holds.
   task automatic run_scan(input string name, input logic [WIDTH-1:0] d,
                           input int hold_after, input int hold_len, input bit poke,
                           input logic [WIDTH-1:0] exp_a, input logic [WIDTH-1:0] exp_b,
                           input int exp_ca, input int exp_cb);
      logic [WIDTH-1:0] seen_a;
      logic [WIDTH-1:0] seen_b;
      int bitk;
      int held;
      int done_cyc;
      int exp_done;
      bit loud;
      bit done_loud;
      seen_a    = '0;
      seen_b    = '0;
      bitk      = 0;
      held      = 0;
      done_cyc  = 0;
      loud      = 1'b0;
      done_loud = 1'b0;
      exp_done  = WIDTH + 1 + hold_len;

      @(negedge clock);
      bus.data  = d;
      bus.hold  = 1'b0;
      bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0;

      for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
         @(negedge clock);
         bus.hold  = (bitk == hold_after) && (held < hold_len);
         bus.start = poke && (cyc == 4 || cyc == exp_done);
         #1;
         if (cyc == 1) begin
            check({name, "/cnt_a_cleared"}, 32'(bus.cnt_a), 32'd0);
            check({name, "/cnt_b_cleared"}, 32'(bus.cnt_b), 32'd0);
         end
         if (bus.done) begin
            done_cyc  = cyc;
            done_loud = bus.hit_a | bus.hit_b;
         end else if (bitk < int'(WIDTH)) begin
            if (bus.hold) begin
               held++;
               if (bus.hit_a | bus.hit_b) loud = 1'b1;
            end else begin
               seen_a[bitk] = bus.hit_a;
               seen_b[bitk] = bus.hit_b;
               bitk++;
            end
         end
      end

      check({name, "/done_cycle"}, 32'(done_cyc), 32'(exp_done));
      check({name, "/hits_a"}, 32'(seen_a), 32'(exp_a));
      check({name, "/hits_b"}, 32'(seen_b), 32'(exp_b));
      check({name, "/cnt_a"}, 32'(bus.cnt_a), 32'(exp_ca));
      check({name, "/cnt_b"}, 32'(bus.cnt_b), 32'(exp_cb));
      check({name, "/done_cycle_hits"}, 32'(done_loud), 32'd0);
      if (hold_len > 0) check({name, "/hits_during_hold"}, 32'(loud), 32'd0);

      @(negedge clock);
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      #1;
      check({name, "/done_one_cycle"}, 32'(bus.done), 32'd0);
      check({name, "/busy_after_done"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      bus.data  = '0;

      #12;
      check("reset/busy", 32'(bus.busy), 32'd0);
      check("reset/done", 32'(bus.done), 32'd0);
      check("reset/cnt_a", 32'(bus.cnt_a), 32'd0);
      check("reset/cnt_b", 32'(bus.cnt_b), 32'd0);
      check("reset/hit_a", 32'(bus.hit_a), 32'd0);
      check("reset/hit_b", 32'(bus.hit_b), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      run_scan("case1", 10'b1001100111, -1, 0, 1'b0, 10'b0001000011, 10'b0000000000, 3, 0);
`ifdef MEALY_SCAN_HIT_MAP_EN
      check("case1/map_a", 32'(bus.map_a), 32'(10'b0001000011));
      check("case1/map_b", 32'(bus.map_b), 32'd0);
`endif
      repeat (2) @(negedge clock);
      #1;
      check("idle/cnt_a_hold", 32'(bus.cnt_a), 32'd3);
      check("idle/busy", 32'(bus.busy), 32'd0);

      run_scan("case2", 10'b0000001101, -1, 0, 1'b0, 10'b0000000001, 10'b0000001000, 1, 1);
      run_scan("case3", 10'b0000001101, 2, 3, 1'b0, 10'b0000000001, 10'b0000001000, 1, 1);
      run_scan("case4", 10'b1001100111, -1, 0, 1'b1, 10'b0001000011, 10'b0000000000, 3, 0);
      run_scan("case4_next", 10'b0000001101, -1, 0, 1'b0, 10'b0000000001, 10'b0000001000, 1, 1);

      // Reset after four consumed bits (hits on bits 0 and 1 already counted).
      @(negedge clock);
      bus.data  = 10'b1001100111;
      bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0;
      repeat (5) @(negedge clock);
      #1;
      check("case5/cnt_a_before_reset", 32'(bus.cnt_a), 32'd2);
      reset = 1'b1;
      #1;
      check("case5/busy", 32'(bus.busy), 32'd0);
      check("case5/done", 32'(bus.done), 32'd0);
      check("case5/cnt_a", 32'(bus.cnt_a), 32'd0);
      check("case5/cnt_b", 32'(bus.cnt_b), 32'd0);
      #1 reset = 1'b0;
      run_scan("case5_rescan", 10'b1001100111, -1, 0, 1'b0, 10'b0001000011, 10'b0000000000, 3, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
